// File: rtl/piso_right_tx_if.sv
// Load handshake and serial-link signals of the right-shifting PISO transmitter.
// The producer/link side uses master; the transmitter itself uses slave.
interface piso_right_tx_if #(
    parameter int DW = 8
);
    logic [DW-1:0] din;
    logic          din_vld;
    logic          din_rdy;
    logic          sout;
    logic          sout_vld;
    logic          sout_last;
    logic          busy;

    modport master (
        output din, din_vld,
        input  din_rdy, sout, sout_vld, sout_last, busy
    );

    modport slave (
        input  din, din_vld,
        output din_rdy, sout, sout_vld, sout_last, busy
    );
endinterface

// File: rtl/piso_right_tx.sv
// Parallel-in serial-out transmitter: loads a DW-bit word over valid/ready
// and emits it LSB-first, one bit per enb-qualified clock.
module piso_right_tx #(
    parameter int DW = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           enb,
    piso_right_tx_if.slave bus
);
    localparam int            CW       = $clog2(DW);
    localparam logic [CW-1:0] LAST_CNT = CW'(DW - 1);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t        state_r, state_nxt;
    logic [DW-1:0] rgstr_r, rgstr_nxt;
    logic [CW-1:0] cnt_r, cnt_nxt;
    logic          last_bit;
    logic          din_rdy_c;
    logic          sout_c;
    logic          sout_vld_c;
    logic          sout_last_c;
    logic          busy_c;

    assign last_bit = (cnt_r == LAST_CNT);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= IDLE;
            rgstr_r <= '0;
            cnt_r   <= '0;
        end else begin
            state_r <= state_nxt;
            rgstr_r <= rgstr_nxt;
            cnt_r   <= cnt_nxt;
        end
    end

    // The last bit doubles as the load slot so back-to-back frames have no gap.
    always_comb begin
        state_nxt   = state_r;
        rgstr_nxt   = rgstr_r;
        cnt_nxt     = cnt_r;
        din_rdy_c   = 1'b0;
        sout_c      = 1'b0;
        sout_vld_c  = 1'b0;
        sout_last_c = 1'b0;
        busy_c      = 1'b0;
        case (state_r)
            IDLE: begin
                din_rdy_c = 1'b1;
                if (bus.din_vld) begin
                    rgstr_nxt = bus.din;
                    cnt_nxt   = '0;
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                sout_c      = rgstr_r[0];
                sout_vld_c  = 1'b1;
                sout_last_c = last_bit;
                busy_c      = 1'b1;
                din_rdy_c   = last_bit & enb;
                if (enb) begin
                    if (!last_bit) begin
                        rgstr_nxt = {1'b0, rgstr_r[DW-1:1]};
                        cnt_nxt   = cnt_r + CW'(1);
                    end else if (bus.din_vld) begin
                        rgstr_nxt = bus.din;
                        cnt_nxt   = '0;
                    end else begin
                        rgstr_nxt = '0;
                        cnt_nxt   = '0;
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign bus.din_rdy   = din_rdy_c;
    assign bus.sout      = sout_c;
    assign bus.sout_vld  = sout_vld_c;
    assign bus.sout_last = sout_last_c;
    assign bus.busy      = busy_c;
endmodule

// File: doc/piso_right_tx.md
Name: piso_right_tx

Overview:
- Parallel-in, serial-out transmitter with a valid/ready load handshake.
- Accepts a DW-bit word and shifts it out LSB-first, one bit per enb-qualified clock.
- Pairs with the team's shift-right serial registers. A DW-bit shift-right receiver clocked on the same enb cycles ends a frame holding the original word.
- Sits between a parallel producer and a serial link; provides frame-valid and last-bit markers.

Parameters:
- DW, 8, word width in bits; legal range DW >= 2; bit counter width is $clog2(DW).

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous active-low reset
- enb  input  1  bit-rate enable; one serial bit is consumed per clock with enb=1
- din  input  DW  parallel word to transmit
- din_vld  input  1  producer has a valid word on din
- din_rdy  output  1  transmitter can accept din this cycle
- sout  output  1  serial data out, LSB first
- sout_vld  output  1  sout carries a frame bit
- sout_last  output  1  current sout bit is the final (MSB) bit of the frame
- busy  output  1  frame in progress (state SHIFT)

Behaviour:
- One clock (clk); reset is asynchronous and active-low (rst).
- Asynchronous reset (rst=0), taking effect immediately regardless of clk:
  - state=IDLE, shift register rgstr_r=0, counter cnt_r=0.
  - Outputs: sout=0, sout_vld=0, sout_last=0, busy=0, din_rdy=1.
  - No load occurs while rst=0.
- States: IDLE, SHIFT.
- IDLE:
  - din_rdy=1, sout_vld=0, sout=0, busy=0.
  - Handshake: on a posedge with din_vld=1, load rgstr_r<=din and cnt_r<=0, then go to SHIFT.
  - Loads are not gated by enb.
  - din_vld=0: stay in IDLE.
- SHIFT:
  - sout=rgstr_r[0], sout_vld=1, busy=1.
  - sout_last=1 iff cnt_r==DW-1.
  - enb=0: all state holds; sout is stable.
  - enb=1 and cnt_r<DW-1: rgstr_r<={1'b0, rgstr_r[DW-1:1]}, cnt_r<=cnt_r+1.
  - enb=1 and cnt_r==DW-1: the last bit is consumed.
    - If din_vld=1: reload rgstr_r<=din, cnt_r<=0 and stay in SHIFT (back-to-back, no idle bit).
    - Otherwise go to IDLE with rgstr_r<=0.
- din_rdy in SHIFT = (cnt_r==DW-1) & enb. This is a combinational path from enb to din_rdy.
- din_vld while din_rdy=0 is ignored; the word is not captured. The producer holds din/din_vld until it sees din_rdy=1.
- Frame length: exactly DW enb-qualified cycles; sout_last is asserted for exactly one enb-qualified cycle per frame.
- Reset mid-frame aborts the frame immediately: sout_vld drops asynchronously and no partial resume occurs.
- No wrap beyond DW-1: cnt_r never exceeds DW-1.

Test Plan:
- Reset: assert rst=0 mid-simulation with random inputs -> sout=0, sout_vld=0, busy=0, din_rdy=1; no load while rst=0.
- Single word, DW=8, din=8'hA5, enb=1 constantly:
  - Required sout sequence 1,0,1,0,0,1,0,1 over 8 cycles.
  - sout_last only on the 8th bit.
  - IDLE on the 9th cycle with din_rdy=1.
- Gapped enb with din=8'h3C and enb toggling 1,0,0,1,...:
  - Each bit is held across enb=0 cycles.
  - The bit order matches 8'h3C LSB-first.
  - Exactly 8 enb-qualified cycles per frame.
- Back-to-back words 8'h01 then 8'h80, din_vld held high:
  - Stream is 1,0,0,0,0,0,0,0,0,0,0,0,0,0,0,1 with no sout_vld gap.
  - sout_last is high twice.
  - din_rdy pulses on the last bit of the first frame.
- Ignored request: pulse din_vld with din=8'hFF at cnt_r=3 during a frame of 8'h00 -> stream stays all zeros and 8'hFF is never transmitted.
- Loopback: feed sout into an 8-bit shift-right register enabled by enb&sout_vld and send 8'hC9 -> after sout_last, the receiver holds 8'hC9; then assert rst=0 mid-second-frame -> busy=0 immediately and a fresh load works afterwards.
